// File: rtl/dual_edge_event_logger.sv
// dual_edge_event_logger: synchronizes two async inputs, timestamps their rising edges
// and queues one record per event in a small FIFO drained over valid/ready.
module dual_edge_event_logger #(
  parameter int MAX_EVENTS = 10,
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ev_a,
  input  logic             ev_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_src,
  output logic [TS_W-1:0]  out_time,
  output logic [CNT_W-1:0] event_count,
  output logic             busy,
  output logic             done,
  output logic             overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] sync_a_q, sync_a_d, sync_b_q, sync_b_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [TS_W+1:0] mem_q [FIFO_DEPTH];
  logic [TS_W+1:0] head;
  logic edge_a, edge_b, empty, full, pop, push;
  // sync_*: {p, s2, s1}
  assign sync_a_d = {sync_a_q[1:0], ev_a};
  assign sync_b_d = {sync_b_q[1:0], ev_b};
  assign edge_a = sync_a_q[1] & ~sync_a_q[2];
  assign edge_b = sync_b_q[1] & ~sync_b_q[2];
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign pop = !empty && out_ready;
  assign push = state_q == ARMED && (edge_a || edge_b) && !start && (!full || pop);
  always_comb begin
    state_d = state_q;
    ts_d = ts_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    wr_d = wr_q;
    rd_d = rd_q;
    if (start) begin
      state_d = ARMED;
      ts_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      wr_d = '0;
      rd_d = '0;
    end else begin
      rd_d = pop ? rd_q + (AW+1)'(1) : rd_q;
      if (state_q == ARMED) begin
        ts_d = ts_q + TS_W'(1);
        if (push) begin
          wr_d = wr_q + (AW+1)'(1);
          cnt_d = cnt_q + CNT_W'(1);
          state_d = (cnt_d == CNT_W'(MAX_EVENTS)) ? DONE : ARMED;
        end else if (edge_a || edge_b) begin
          ovf_d = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_a_q <= '0;
      sync_b_q <= '0;
      ts_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      sync_a_q <= sync_a_d;
      sync_b_q <= sync_b_d;
      ts_q <= ts_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // storage needs no reset: the head is masked whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {edge_b, edge_a, ts_q};
  end
  assign head = mem_q[rd_q[AW-1:0]];
  assign out_valid = !empty;
  assign out_src = out_valid ? head[TS_W+1:TS_W] : 2'b00;
  assign out_time = out_valid ? head[TS_W-1:0] : '0;
  assign event_count = cnt_q;
  assign busy = state_q == ARMED;
  assign done = state_q == DONE;
  assign overflow = ovf_q;
endmodule
